// File: rtl/soc_region_pkg.sv
// Shared types and default SoC address map for the runtime region table.
// Attribute encoding is {idempotent, cached, exec}.
package soc_region_pkg;

   typedef struct packed {
      logic idempotent;
      logic cached;
      logic exec;
   } region_attr_t;

   localparam int unsigned RuleAddrWidth = 64;

   typedef struct packed {
      logic [RuleAddrWidth-1:0] base;
      logic [RuleAddrWidth-1:0] len;
      region_attr_t             attr;
      logic                     lock;
   } region_rule_t;

   localparam logic [63:0] DebugBase = 64'h0000_0000, DebugLen = 64'h0000_1000;
   localparam logic [63:0] RomBase   = 64'h0001_0000, RomLen   = 64'h0001_0000;
   localparam logic [63:0] ClintBase = 64'h0200_0000, ClintLen = 64'h000C_0000;
   localparam logic [63:0] PlicBase  = 64'h0C00_0000, PlicLen  = 64'h03FF_FFFF;
   localparam logic [63:0] UartBase  = 64'h1000_0000, UartLen  = 64'h0000_1000;
   localparam logic [63:0] SpiBase   = 64'h2000_0000, SpiLen   = 64'h0080_0000;
   localparam logic [63:0] EthBase   = 64'h3000_0000, EthLen   = 64'h0001_0000;
   localparam logic [63:0] GpioBase  = 64'h4000_0000, GpioLen  = 64'h0000_1000;
   localparam logic [63:0] DramBase  = 64'h8000_0000, DramLen  = 64'h4000_0000;

   localparam logic [2:0] DebugAttr = 3'b001;
   localparam logic [2:0] RomAttr   = 3'b011;
   localparam logic [2:0] DevAttr   = 3'b000;
   localparam logic [2:0] DramAttr  = 3'b111;

   // Rule i sits at slice [i*64 +: 64]; lower index has higher priority.
   localparam int unsigned SocNrRules = 9;
   localparam logic [SocNrRules*64-1:0] SocRstBase = {
      DramBase, GpioBase, EthBase, SpiBase, UartBase,
      PlicBase, ClintBase, RomBase, DebugBase};
   localparam logic [SocNrRules*64-1:0] SocRstLen = {
      DramLen, GpioLen, EthLen, SpiLen, UartLen,
      PlicLen, ClintLen, RomLen, DebugLen};
   localparam logic [SocNrRules*3-1:0] SocRstAttr = {
      DramAttr, DevAttr, DevAttr, DevAttr, DevAttr,
      DevAttr, DevAttr, RomAttr, DebugAttr};

endpackage

// File: rtl/soc_region_prio_match.sv
// Combinational region compare with lowest-index-wins priority encoding.
// Outputs hit, winning index and its attributes (attributes zero on a miss).
module soc_region_prio_match
   import soc_region_pkg::*;
#(
   parameter int unsigned NrRules   = 9,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned IdxWidth  = 4
) (
   input  logic [AddrWidth-1:0]              addr,
   input  logic [NrRules-1:0][AddrWidth-1:0] base,
   input  logic [NrRules-1:0][AddrWidth-1:0] len,
   input  region_attr_t [NrRules-1:0]        attr,
   output logic                              hit,
   output logic [IdxWidth-1:0]               idx,
   output region_attr_t                      match_attr
);

   logic [NrRules-1:0] match;

   // Offset form avoids base+len overflow, so a region ending at 2^AddrWidth
   // still matches; a zero length can never satisfy offset < len.
   always_comb begin
      match = '0;
      for (int i = 0; i < NrRules; i++) begin
         match[i] = (addr >= base[i]) && ((addr - base[i]) < len[i]);
      end
   end

   always_comb begin
      hit        = 1'b0;
      idx        = '0;
      match_attr = '0;
      for (int i = 0; i < NrRules; i++) begin
         if (match[i] && !hit) begin
            hit        = 1'b1;
            idx        = IdxWidth'(i);
            match_attr = attr[i];
         end
      end
   end

endmodule

// File: rtl/soc_region_map.sv
// Runtime-programmable SoC region table with a registered lookup port.
// Define SOC_REGION_MAP_LOCK_EN to implement per-rule write locks.
module soc_region_map
   import soc_region_pkg::*;
#(
   parameter int unsigned NrRules   = 9,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1,
   parameter logic [NrRules*AddrWidth-1:0] RstBase = '0,
   parameter logic [NrRules*AddrWidth-1:0] RstLen  = '0,
   parameter logic [NrRules*3-1:0]         RstAttr = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_we_i,
   input  logic [IdxWidth-1:0]  cfg_idx_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [AddrWidth-1:0] cfg_len_i,
   input  logic [2:0]           cfg_attr_i,
   input  logic                 cfg_lock_i,
   output logic                 cfg_err_o,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic                 resp_hit_o,
   output logic [IdxWidth-1:0]  resp_idx_o,
   output logic [2:0]           resp_attr_o,
   output logic [15:0]          miss_cnt_o
);

   logic [NrRules-1:0][AddrWidth-1:0] base_q;
   logic [NrRules-1:0][AddrWidth-1:0] len_q;
   region_attr_t [NrRules-1:0]        attr_q;

   logic idx_in_range;
   logic idx_locked;
   logic wr_accept;
   logic req_fire;

   logic                match_hit;
   logic [IdxWidth-1:0] match_idx;
   region_attr_t        match_attr;

   assign idx_in_range = 32'(cfg_idx_i) < NrRules;

`ifdef SOC_REGION_MAP_LOCK_EN
   logic [NrRules-1:0] lock_q;

   assign idx_locked = idx_in_range && lock_q[cfg_idx_i];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lock_q <= '0;
      end else if (wr_accept && cfg_lock_i) begin
         lock_q[cfg_idx_i] <= 1'b1;
      end
   end
`else
   logic unused_cfg_lock;

   assign idx_locked      = 1'b0;
   assign unused_cfg_lock = cfg_lock_i;
`endif

   assign wr_accept = cfg_we_i && idx_in_range && !idx_locked;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NrRules; i++) begin
            base_q[i] <= RstBase[i*AddrWidth +: AddrWidth];
            len_q[i]  <= RstLen[i*AddrWidth +: AddrWidth];
            attr_q[i] <= region_attr_t'(RstAttr[i*3 +: 3]);
         end
      end else if (wr_accept) begin
         base_q[cfg_idx_i] <= cfg_base_i;
         len_q[cfg_idx_i]  <= cfg_len_i;
         attr_q[cfg_idx_i] <= region_attr_t'(cfg_attr_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cfg_err_o <= 1'b0;
      end else begin
         cfg_err_o <= cfg_we_i && !wr_accept;
      end
   end

   // Matching runs on the pre-write table, so a same-cycle write is not visible.
   soc_region_prio_match #(
      .NrRules   (NrRules),
      .AddrWidth (AddrWidth),
      .IdxWidth  (IdxWidth)
   ) u_prio_match (
      .addr       (req_addr_i),
      .base       (base_q),
      .len        (len_q),
      .attr       (attr_q),
      .hit        (match_hit),
      .idx        (match_idx),
      .match_attr (match_attr)
   );

   assign req_ready_o = !resp_valid_o || resp_ready_i;
   assign req_fire    = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         resp_valid_o <= 1'b0;
         resp_hit_o   <= 1'b0;
         resp_idx_o   <= '0;
         resp_attr_o  <= '0;
         miss_cnt_o   <= '0;
      end else begin
         if (req_fire) begin
            resp_valid_o <= 1'b1;
            resp_hit_o   <= match_hit;
            resp_idx_o   <= match_idx;
            resp_attr_o  <= match_attr;
            if (!match_hit && (miss_cnt_o != 16'hFFFF)) begin
               miss_cnt_o <= miss_cnt_o + 16'd1;
            end
         end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_soc_region_map.sv
// Self-checking bench for soc_region_map: directed cases plus random traffic
// against a table-level reference model. Honours SOC_REGION_MAP_LOCK_EN.
module tb_soc_region_map;
   import soc_region_pkg::*;

   localparam int unsigned NR = 9;
   localparam int unsigned AW = 64;
   localparam int unsigned IW = 4;
`ifdef SOC_REGION_MAP_LOCK_EN
   localparam bit LockEn = 1'b1;
`else
   localparam bit LockEn = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cfg_we_i;
   logic [IW-1:0] cfg_idx_i;
   logic [AW-1:0] cfg_base_i;
   logic [AW-1:0] cfg_len_i;
   logic [2:0]    cfg_attr_i;
   logic          cfg_lock_i;
   logic          cfg_err_o;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic          resp_hit_o;
   logic [IW-1:0] resp_idx_o;
   logic [2:0]    resp_attr_o;
   logic [15:0]   miss_cnt_o;

   always #5 clk_i = ~clk_i;

   soc_region_map #(
      .NrRules   (NR),
      .AddrWidth (AW),
      .RstBase   (SocRstBase),
      .RstLen    (SocRstLen),
      .RstAttr   (SocRstAttr)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cfg_we_i     (cfg_we_i),
      .cfg_idx_i    (cfg_idx_i),
      .cfg_base_i   (cfg_base_i),
      .cfg_len_i    (cfg_len_i),
      .cfg_attr_i   (cfg_attr_i),
      .cfg_lock_i   (cfg_lock_i),
      .cfg_err_o    (cfg_err_o),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_hit_o   (resp_hit_o),
      .resp_idx_o   (resp_idx_o),
      .resp_attr_o  (resp_attr_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference table and expected response state.
   logic [63:0] m_base [NR];
   logic [63:0] m_len  [NR];
   logic [2:0]  m_attr [NR];
   bit          m_lock [NR];
   bit          e_valid, e_hit, e_err;
   int          e_idx, e_miss;
   logic [2:0]  e_attr;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void ref_lookup(input logic [63:0] a, output bit h, output int ix,
                                      output logic [2:0] at);
      h = 0; ix = 0; at = 3'b000;
      for (int i = 0; i < NR; i++) begin
         if (!h && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
            h = 1; ix = i; at = m_attr[i];
         end
      end
   endfunction

   function automatic void ref_reset();
      for (int i = 0; i < NR; i++) begin
         m_base[i] = SocRstBase[i*64 +: 64];
         m_len[i]  = SocRstLen[i*64 +: 64];
         m_attr[i] = SocRstAttr[i*3 +: 3];
         m_lock[i] = 0;
      end
      e_valid = 0; e_hit = 0; e_idx = 0; e_attr = 3'b000; e_miss = 0; e_err = 0;
   endfunction

   // One clock: check ready, predict the edge, then check registered outputs.
   task automatic step();
      bit acc, h, bad;
      int ix, wi;
      logic [2:0] at;
      #1;
      chk("req_ready", req_ready_o, !e_valid || resp_ready_i);
      acc = req_valid_i && (!e_valid || resp_ready_i);
      h = 0; ix = 0; at = 3'b000;
      if (acc) ref_lookup(req_addr_i, h, ix, at);
      wi  = int'(cfg_idx_i);
      bad = (wi >= NR) || (LockEn && m_lock[wi]);
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
         ref_reset();
      end else begin
         if (acc) begin
            e_valid = 1; e_hit = h; e_idx = ix; e_attr = at;
            if (!h && e_miss < 16'hFFFF) e_miss++;
         end else if (resp_ready_i) begin
            e_valid = 0;
         end
         e_err = cfg_we_i && bad;
         if (cfg_we_i && !bad) begin
            m_base[wi] = cfg_base_i;
            m_len[wi]  = cfg_len_i;
            m_attr[wi] = cfg_attr_i;
            if (cfg_lock_i) m_lock[wi] = 1;
         end
      end
      chk("resp_valid", resp_valid_o, e_valid);
      if (e_valid || !rst_ni) begin
         chk("resp_hit", resp_hit_o, e_hit);
         chk("resp_idx", resp_idx_o, e_idx);
         chk("resp_attr", resp_attr_o, e_attr);
      end
      chk("miss_cnt", miss_cnt_o, e_miss);
      chk("cfg_err", cfg_err_o, e_err);
   endtask

   task automatic do_write(input int idx, input logic [63:0] b, input logic [63:0] l,
                           input logic [2:0] at, input bit lk);
      cfg_we_i = 1; cfg_idx_i = IW'(idx); cfg_base_i = b; cfg_len_i = l;
      cfg_attr_i = at; cfg_lock_i = lk;
      step();
      cfg_we_i = 0; cfg_lock_i = 0;
   endtask

   task automatic do_lookup(input logic [63:0] a);
      req_valid_i = 1; resp_ready_i = 1; req_addr_i = a;
      step();
      req_valid_i = 0;
   endtask

   task automatic do_reset();
      rst_ni = 0;
      step();
      rst_ni = 1;
   endtask

   initial begin
      logic [63:0] a;
      int r;
      rst_ni = 0; cfg_we_i = 0; cfg_idx_i = '0; cfg_base_i = '0; cfg_len_i = '0;
      cfg_attr_i = '0; cfg_lock_i = 0; req_valid_i = 0; req_addr_i = '0; resp_ready_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      ref_reset();
      step();
      chk("rst_ready", req_ready_o, 1);
      chk("rst_valid", resp_valid_o, 0);
      rst_ni = 1;

      // Default table hits and misses.
      do_lookup(64'h8000_1000);
      chk("dram_hit", resp_hit_o, 1);
      chk("dram_idx", resp_idx_o, 8);
      chk("dram_attr", resp_attr_o, DramAttr);
      do_lookup(64'h5000_0000);
      chk("hole_hit", resp_hit_o, 0);
      chk("hole_attr", resp_attr_o, 0);
      chk("hole_miss_cnt", miss_cnt_o, 1);
      step();

      // Overlap priority and region ending at the top of the address space.
      do_write(2, 64'h8000_0000, 64'h1000, 3'b101, 0);
      do_lookup(64'h8000_0800);
      chk("ovl_low_idx", resp_idx_o, 2);
      do_lookup(64'h8000_1000);
      chk("ovl_high_idx", resp_idx_o, 8);
      do_write(0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b001, 0);
      do_lookup(64'hFFFF_FFFF_FFFF_FFFF);
      chk("top_hit", resp_hit_o, 1);
      chk("top_idx", resp_idx_o, 0);
      step();

      // Backpressure: first response held while two more requests wait.
      req_valid_i = 1; resp_ready_i = 1; req_addr_i = 64'h0001_0004;
      step();
      resp_ready_i = 0; req_addr_i = 64'h4000_0010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_ready", req_ready_o, 0);
         chk("bp_idx", resp_idx_o, 1);
      end
      resp_ready_i = 1;
      step();
      chk("bp_second_idx", resp_idx_o, 7);
      req_addr_i = 64'h1000_0000;
      step();
      chk("bp_third_idx", resp_idx_o, 4);
      req_valid_i = 0;
      step();
      chk("bp_drain", resp_valid_o, 0);

      // Lock behaviour, then reset clears it.
      do_write(5, 64'h2000_0000, 64'h1000, 3'b011, 1);
      do_write(5, 64'h0, 64'h1000, 3'b000, 0);
      chk("lock_err", cfg_err_o, LockEn);
      do_lookup(64'h2000_0800);
      chk("lock_keep", resp_hit_o, LockEn);
      do_reset();
      do_write(5, 64'h0, 64'h1000, 3'b000, 0);
      chk("relock_err", cfg_err_o, 0);

      // Same-cycle write and lookup sees the old rule 4.
      do_reset();
      cfg_we_i = 1; cfg_idx_i = IW'(4); cfg_base_i = 64'h1100_0000; cfg_len_i = 64'h1000;
      cfg_attr_i = 3'b010; cfg_lock_i = 0;
      req_valid_i = 1; resp_ready_i = 1; req_addr_i = 64'h1000_0000;
      step();
      cfg_we_i = 0;
      chk("same_cycle_hit", resp_hit_o, 1);
      chk("same_cycle_idx", resp_idx_o, 4);
      step();
      chk("next_cycle_hit", resp_hit_o, 0);
      req_valid_i = 0;

      // Out-of-range rule index.
      do_write(NR, 64'h0, 64'h1000, 3'b000, 0);
      chk("oor_err", cfg_err_o, 1);
      step();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst_ni     = ($urandom_range(0, 499) != 0);
         cfg_we_i   = ($urandom_range(0, 7) == 0);
         cfg_idx_i  = IW'($urandom_range(0, 10));
         cfg_base_i = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_F000
                      : {32'h0, 4'($urandom_range(0, 15)), 28'h0};
         case ($urandom_range(0, 3))
            0:       cfg_len_i = 64'h0;
            1:       cfg_len_i = 64'h1000;
            2:       cfg_len_i = 64'h1000_0000;
            default: cfg_len_i = {32'h0, $urandom};
         endcase
         cfg_attr_i   = 3'($urandom_range(0, 7));
         cfg_lock_i   = ($urandom_range(0, 3) == 0);
         req_valid_i  = ($urandom_range(0, 3) != 0);
         resp_ready_i = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, NR - 1);
         case ($urandom_range(0, 5))
            0:       a = m_base[r];
            1:       a = m_base[r] + m_len[r] - 64'd1;
            2:       a = m_base[r] + m_len[r];
            3:       a = m_base[r] - 64'd1;
            4:       a = (m_len[r] != 0) ? m_base[r] + ({$urandom, $urandom} % m_len[r])
                                         : m_base[r];
            default: a = {$urandom, $urandom};
         endcase
         req_addr_i = a;
         step();
      end
      rst_ni = 1; cfg_we_i = 0; cfg_lock_i = 0; req_valid_i = 0; resp_ready_i = 1;
      step();

      // Miss counter saturation.
      do_reset();
      req_valid_i = 1; resp_ready_i = 1; req_addr_i = 64'h5000_0000;
      for (int n = 0; n < 70000; n++) step();
      chk("miss_sat", miss_cnt_o, 16'hFFFF);
      req_valid_i = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
